// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin UART TX arbiter with locked multi-byte packets
// Optional watchdog enabled by defining UART_TX_ARB_TIMEOUT_EN.

module uart_tx_arbiter #(
  parameter int N_REQ          = 2,
  parameter int WORD_LENGTH    = 8,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                         i_clock,
  input  logic                         i_reset,
  input  logic [N_REQ-1:0]             i_req,
  input  logic [N_REQ-1:0]             i_last,
  input  logic [N_REQ*WORD_LENGTH-1:0] i_data,
  input  logic                         i_tx_done,
  output logic                         o_tx_start,
  output logic [WORD_LENGTH-1:0]       o_data_tx,
  output logic [N_REQ-1:0]             o_grant,
  output logic [N_REQ-1:0]             o_ack,
  output logic                         o_busy,
  output logic                         o_timeout
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, SEND, WAIT, ACK} state_t;

  state_t                 state_q, state_d;
  logic [N_REQ-1:0]       grant_q, grant_d;
  logic [WORD_LENGTH-1:0] data_q, data_d;
  logic                   lock_q, lock_d;
  logic [PW-1:0]          ptr_q, ptr_d;
  logic                   prev_done_q;
  logic                   done_edge;
  logic                   expire;
  logic                   found;
  logic [PW-1:0]          sel;
  int                     pick_idx;

  assign done_edge = i_tx_done & ~prev_done_q;

  // A locked owner keeps the transmitter; otherwise search upward from pointer+1.
  always_comb begin
    found    = 1'b0;
    sel      = ptr_q;
    pick_idx = 0;
    if (lock_q && i_req[ptr_q]) begin
      found = 1'b1;
    end else begin
      for (int i = 1; i <= N_REQ; i++) begin
        pick_idx = int'(ptr_q) + i;
        if (pick_idx >= N_REQ) pick_idx = pick_idx - N_REQ;
        if (!found && i_req[pick_idx[PW-1:0]]) begin
          found = 1'b1;
          sel   = pick_idx[PW-1:0];
        end
      end
    end
  end

`ifdef UART_TX_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  always_comb begin
    wd_cnt_d = '0;
    if (state_q == WAIT) wd_cnt_d = wd_cnt_q + 16'd1;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) wd_cnt_q <= '0;
    else         wd_cnt_q <= wd_cnt_d;
  end

  // A done edge in the expiry cycle takes priority over the watchdog.
  assign expire = (state_q == WAIT) && !done_edge && (wd_cnt_q == 16'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign expire = 1'b0;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      data_q      <= '0;
      lock_q      <= 1'b0;
      ptr_q       <= PW'(N_REQ - 1);
      prev_done_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      data_q      <= data_d;
      lock_q      <= lock_d;
      ptr_q       <= ptr_d;
      prev_done_q <= i_tx_done;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    data_d  = data_q;
    lock_d  = lock_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_d = N_REQ'(1) << sel;
          data_d  = i_data[int'(sel)*WORD_LENGTH +: WORD_LENGTH];
          lock_d  = ~i_last[sel];
          ptr_d   = sel;
          state_d = SEND;
        end else begin
          grant_d = '0;
          lock_d  = 1'b0;
        end
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (done_edge) begin
          state_d = ACK;
        end else if (expire) begin
          state_d = IDLE;
          grant_d = '0;
          lock_d  = 1'b0;
        end
      end
      ACK: begin
        state_d = IDLE;
        if (!lock_q) grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_tx_start = (state_q == SEND);
    o_busy     = (state_q != IDLE);
    o_ack      = (state_q == ACK) ? grant_q : '0;
    o_grant    = grant_q;
    o_data_tx  = data_q;
    o_timeout  = expire;
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
// Timeout scenario runs only when UART_TX_ARB_TIMEOUT_EN is defined.

module tb_uart_tx_arbiter;
  localparam int N  = 2;
  localparam int W  = 8;
  localparam int TO = 50;
  localparam int UD = 20;
`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   last = '0;
  logic [N*W-1:0] data = '0;
  logic           done = 1'b0;
  logic           tx_start, busy, tmo;
  logic [W-1:0]   data_tx;
  logic [N-1:0]   grant, ack;

  uart_tx_arbiter #(.N_REQ(N), .WORD_LENGTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .i_clock(clk), .i_reset(rst), .i_req(req), .i_last(last), .i_data(data),
    .i_tx_done(done), .o_tx_start(tx_start), .o_data_tx(data_tx), .o_grant(grant),
    .o_ack(ack), .o_busy(busy), .o_timeout(tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // Requester byte queues: {last, byte}
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [7:0] log_d[$];
  int         log_c[$];
  int         ack_c[$];
  int         to_c[$];
  int         ucnt  = 0;
  bit         umute = 1'b0;

  // Transaction-level model: a byte is "in flight" from its grant decision until its ack.
  int         cyc = 0;
  bit         m_txn = 1'b0, m_hold = 1'b0, m_prev = 1'b1;
  int         m_owner = 0, m_ptr = N - 1, m_start = 0, m_ack = -1;
  logic [7:0] m_data = '0;
  int         mc, mw;
  bit         me;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_txn = 1'b0; m_hold = 1'b0; m_prev = 1'b1;
      m_owner = 0; m_ptr = N - 1; m_ack = -1; m_data = '0;
    end else begin
      mc = cyc;
      cyc = cyc + 1;
      me = done && !m_prev;
      m_prev = done;
      if (!m_txn) begin
        mw = -1;
        if (m_hold && req[m_owner]) mw = m_owner;
        else for (int k = 1; k <= N; k++) if (mw < 0 && req[(m_ptr + k) % N]) mw = (m_ptr + k) % N;
        if (mw >= 0) begin
          m_txn = 1'b1; m_owner = mw; m_data = data[mw*W +: W];
          m_hold = !last[mw]; m_ptr = mw; m_start = mc + 1; m_ack = -1;
        end else begin
          m_hold = 1'b0;
        end
      end else if (mc == m_ack) begin
        m_txn = 1'b0;
      end else if (mc > m_start && m_ack < 0 && me) begin
        m_ack = mc + 1;
      end else if (TO_EN && m_ack < 0 && mc == m_start + TO) begin
        m_txn = 1'b0; m_hold = 1'b0;
      end
    end
  end

  logic [N-1:0] e_grant, e_ack;
  bit           e_to;

  // Compare, log, then drive the UART model and requesters for the next cycle.
  always @(negedge clk) begin
    e_grant = (m_txn || m_hold) ? N'(1 << m_owner) : '0;
    e_ack   = (m_txn && cyc == m_ack) ? N'(1 << m_owner) : '0;
    e_to    = TO_EN && m_txn && m_ack < 0 && cyc == m_start + TO && !(done && !m_prev);
    chk("grant", grant, e_grant);
    chk("ack", ack, e_ack);
    chk("busy", busy, m_txn);
    chk("tx_start", tx_start, m_txn && cyc == m_start);
    chk("data_tx", data_tx, m_data);
    chk("timeout", tmo, e_to);

    if (tx_start) begin log_d.push_back(data_tx); log_c.push_back(cyc); end
    if (ack != '0) ack_c.push_back(cyc);
    if (tmo) to_c.push_back(cyc);
    if (ack[0] && q0.size() > 0) void'(q0.pop_front());
    if (ack[1] && q1.size() > 0) void'(q1.pop_front());

    if (rst) ucnt = 0;
    else if (tx_start) begin
      done = 1'b0;
      ucnt = umute ? 0 : UD;
    end else if (ucnt > 0) begin
      ucnt--;
      if (ucnt == 0) done = 1'b1;
    end

    req[0] = q0.size() > 0;
    req[1] = q1.size() > 0;
    last[0] = (q0.size() > 0) ? q0[0][8] : 1'b0;
    last[1] = (q1.size() > 0) ? q1[0][8] : 1'b0;
    data[7:0]  = (q0.size() > 0) ? q0[0][7:0] : 8'h00;
    data[15:8] = (q1.size() > 0) ? q1[0][7:0] : 8'h00;
  end

  task automatic clear_logs();
    log_d.delete(); log_c.delete(); ack_c.delete(); to_c.delete();
  endtask

  task automatic do_reset(input bit dn);
    @(negedge clk); #1;
    rst = 1'b1; done = dn;
    q0.delete(); q1.delete();
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_log(input int n, input int budget);
    int k = 0;
    while (log_d.size() < n && k < budget) begin @(negedge clk); #1; k++; end
    chk("wait_log", log_d.size() >= n, 1);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    while ((q0.size() > 0 || q1.size() > 0 || busy) && k < budget) begin @(negedge clk); #1; k++; end
    chk("wait_idle", k < budget, 1);
  endtask

  int t_req;

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_data", data_tx, 0);
    chk("rst_start", tx_start, 0);

    // single byte from requester 0
    do_reset(1'b0);
    q0.push_back({1'b1, 8'h5A});
    t_req = cyc + 1;
    wait_idle(500);
    chk("t1_count", log_d.size(), 1);
    chk("t1_byte", log_d[0], 8'h5A);
    chk("t1_start_lat", log_c[0] - t_req, 1);
    chk("t1_ack_lat", ack_c[0] - log_c[0], UD + 1);
    chk("t1_grant_idle", grant, 0);
    chk("t1_busy_idle", busy, 0);

    // round-robin alternation
    do_reset(1'b0);
    q0.push_back({1'b1, 8'h11}); q0.push_back({1'b1, 8'h11});
    q1.push_back({1'b1, 8'h22}); q1.push_back({1'b1, 8'h22});
    wait_idle(500);
    chk("t2_count", log_d.size(), 4);
    chk("t2_b0", log_d[0], 8'h11);
    chk("t2_b1", log_d[1], 8'h22);
    chk("t2_b2", log_d[2], 8'h11);
    chk("t2_b3", log_d[3], 8'h22);

    // locked 3-byte packet from requester 1 while requester 0 waits
    do_reset(1'b0);
    q1.push_back({1'b0, 8'hA1}); q1.push_back({1'b0, 8'hA2}); q1.push_back({1'b1, 8'hA3});
    wait_log(1, 100);
    q0.push_back({1'b1, 8'h30});
    wait_idle(500);
    chk("t3_count", log_d.size(), 4);
    chk("t3_b0", log_d[0], 8'hA1);
    chk("t3_b1", log_d[1], 8'hA2);
    chk("t3_b2", log_d[2], 8'hA3);
    chk("t3_b3", log_d[3], 8'h30);
    chk("t3_gap", log_c[1] - ack_c[0], 2);

    // done high through reset release is not an edge
    do_reset(1'b1);
    repeat (5) @(negedge clk);
    #1;
    chk("t4_no_ack", ack_c.size(), 0);
    q0.push_back({1'b1, 8'h4D});
    wait_idle(500);
    chk("t4_acks", ack_c.size(), 1);
    chk("t4_ack_lat", ack_c[0] - log_c[0], UD + 1);

    // asynchronous reset in WAIT, then requester 0 first again
    do_reset(1'b0);
    q0.push_back({1'b1, 8'h55});
    wait_log(1, 100);
    repeat (5) @(negedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("t5_grant", grant, 0);
    chk("t5_busy", busy, 0);
    chk("t5_data", data_tx, 0);
    clear_logs();
    q1.push_back({1'b1, 8'h66});
    @(negedge clk); #1;
    rst = 1'b0;
    wait_idle(500);
    chk("t5_count", log_d.size(), 2);
    chk("t5_b0", log_d[0], 8'h55);
    chk("t5_b1", log_d[1], 8'h66);

`ifdef UART_TX_ARB_TIMEOUT_EN
    do_reset(1'b0);
    umute = 1'b1;
    q0.push_back({1'b1, 8'h77});
    q1.push_back({1'b1, 8'h88});
    wait_log(1, 100);
    umute = 1'b0;
    wait_idle(800);
    chk("to_pulses", to_c.size(), 1);
    chk("to_lat", to_c[0] - log_c[0], TO);
    chk("to_next", log_d[1], 8'h88);
    chk("to_retry", log_d[2], 8'h77);
    chk("to_acks", ack_c.size(), 2);
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #200000;
    fails++;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $fatal(1);
  end

endmodule
